// File: rtl/function_package.sv
// Shared GF(2^8) helpers and the MixColumns engine state type.
package function_package;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // xtime: multiply by 2 modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
    function automatic logic [7:0] galois_mult_2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // multiply by 3 = xtime(a) ^ a
    function automatic logic [7:0] galois_mult_3(input logic [7:0] a);
        return galois_mult_2(a) ^ a;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column (byte 0 in the MSBs).
module mix_single_column
    import function_package::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    // Fixed circulant matrix {2,3,1,1} applied over GF(2^8)
    always_comb begin
        o_col[31:24] = galois_mult_2(w_a0) ^ galois_mult_3(w_a1) ^ w_a2 ^ w_a3;
        o_col[23:16] = w_a0 ^ galois_mult_2(w_a1) ^ galois_mult_3(w_a2) ^ w_a3;
        o_col[15:8]  = w_a0 ^ w_a1 ^ galois_mult_2(w_a2) ^ galois_mult_3(w_a3);
        o_col[7:0]   = galois_mult_3(w_a0) ^ w_a1 ^ w_a2 ^ galois_mult_2(w_a3);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: one shared column mixer, four clocks per state.
module mix_columns_seq
    import function_package::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_col_cnt;
    logic [127:0] r_in_buf;
    logic [127:0] r_data_out;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign data_out  = r_data_out;

    // Select the captured column currently being mixed
    always_comb begin
        w_col_in = r_in_buf[127:96];
        case (r_col_cnt)
            2'd0: w_col_in = r_in_buf[127:96];
            2'd1: w_col_in = r_in_buf[95:64];
            2'd2: w_col_in = r_in_buf[63:32];
            2'd3: w_col_in = r_in_buf[31:0];
            default: w_col_in = r_in_buf[127:96];
        endcase
    end

    mix_single_column u_mix (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    // Next-state decode: accept in IDLE, four mixing cycles, hold until consumed
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)            w_state_next = BUSY;
            BUSY:    if (r_col_cnt == 2'd3)   w_state_next = DONE;
            DONE:    if (out_ready)           w_state_next = IDLE;
            default:                          w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: capture on accept, write one mixed column per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt  <= '0;
            r_in_buf   <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_buf  <= data_in;
                        r_col_cnt <= '0;
                    end
                end
                BUSY: begin
                    r_col_cnt <= r_col_cnt + 2'd1;
                    case (r_col_cnt)
                        2'd0: r_data_out[127:96] <= w_col_out;
                        2'd1: r_data_out[95:64]  <= w_col_out;
                        2'd2: r_data_out[63:32]  <= w_col_out;
                        2'd3: r_data_out[31:0]   <= w_col_out;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a matrix-based MixColumns model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input int unsigned k);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] s);
        int unsigned m [4][4];
        logic [127:0] r;
        logic [7:0]   acc;
        m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], m[row][j]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [127:0] q[$];
    int           cyc       = 0;
    int           acc_cyc   = 0;
    int           last_hs   = -1;
    bit           streaming = 1'b0;
    bit           have_last = 1'b0;
    logic [127:0] last_out;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            have_last = 1'b0;
        end else begin
            chk("in_ready", {127'd0, in_ready}, {127'd0, (q.size() == 0)});
            chk("out_valid", {127'd0, out_valid},
                {127'd0, (q.size() > 0) && ((cyc - acc_cyc) >= 5)});
            if (out_valid && have_last)
                chk("hold_stable", data_out, last_out);
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    chk("result", data_out, q[0]);
                    void'(q.pop_front());
                end else begin
                    chk("unexpected_output", {127'd0, out_valid}, 128'd0);
                end
                if (streaming && last_hs >= 0)
                    chk("stream_period", 128'(cyc - last_hs), 128'd6);
                last_hs   = cyc;
                have_last = 1'b0;
            end else if (out_valid) begin
                last_out  = data_out;
                have_last = 1'b1;
            end else begin
                have_last = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(mixcols(data_in));
                acc_cyc = cyc;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (!in_ready) chk("send_timeout", 128'd0, 128'd1);
        in_valid = 1'b1;
        data_in  = d;
        step();
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 20) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            step();
            t++;
        end
        if (!out_valid) chk("valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0) && t < 200) begin
            step();
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 128'd0);
    endtask

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    initial begin
        logic [127:0] x;
        logic [127:0] held;
        int n_acc;
        int t;
        bit acc_now;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;

        chk("model_v1", mixcols(V1), R1);
        chk("model_v2", mixcols(V2), R2);

        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_data_out", data_out, 128'd0);

        // known vector
        out_ready = 1'b1;
        send(V1);
        wait_valid();
        chk("vec1", data_out, R1);
        step();

        // second vector, data_in scrambled every cycle after acceptance
        send(V2);
        wait_valid();
        chk("vec2", data_out, R2);
        step();

        // back-pressure with an ignored input pulse
        out_ready = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        send(V1);
        wait_valid();
        held = data_out;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                data_in  = x;
            end
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            step();
            in_valid = 1'b0;
        end
        chk("bp_data_held", data_out, held);
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
        send(x);
        wait_valid();
        chk("bp_new_state", data_out, mixcols(x));
        step();

        // streaming: 8 random states, one result per 6 clocks
        streaming = 1'b1;
        last_hs   = -1;
        n_acc     = 0;
        t         = 0;
        in_valid  = 1'b1;
        data_in   = {$urandom, $urandom, $urandom, $urandom};
        while (n_acc < 8 && t < 200) begin
            acc_now = in_ready;
            step();
            t++;
            if (acc_now) begin
                n_acc++;
                data_in = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", 128'(n_acc), 128'd8);
        drain();
        streaming = 1'b0;

        // reset during the second BUSY cycle aborts the block
        send(V2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        chk("abort_data_out", data_out, 128'd0);
        for (int i = 0; i < 8; i++) step();

        // random states with random consumer stalls
        for (int k = 0; k < 6; k++) begin
            send({$urandom, $urandom, $urandom, $urandom});
            t = 0;
            while (q.size() != 0 && t < 100) begin
                out_ready = $urandom_range(0, 1);
                step();
                t++;
            end
            if (q.size() != 0) chk("rand_timeout", 128'(q.size()), 128'd0);
            out_ready = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
